// File: rtl/module_muldiv.sv
// Sequential RV32M multiply/divide unit: one multiplier/quotient bit per clock,
// fixed 33-edge latency from accept to done, registered result.
module module_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] reg_in_a,
  input  logic [WIDTH-1:0] reg_in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [2:0]             op;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic                   neg;
  logic [2*WIDTH-1:0]     acc;   // mul: {partial product, multiplier}; div: low half is dividend/quotient
  logic [WIDTH:0]         rem;

  // operand decode at accept
  logic                   a_neg, b_neg, neg_in;
  logic [WIDTH-1:0]       a_mag_in, b_mag_in;

  always_comb begin
    a_neg  = (func inside {3'd1, 3'd2, 3'd4, 3'd6}) && reg_in_a[WIDTH-1];
    b_neg  = (func inside {3'd1, 3'd4, 3'd6}) && reg_in_b[WIDTH-1];
    a_mag_in = a_neg ? -reg_in_a : reg_in_a;
    b_mag_in = b_neg ? -reg_in_b : reg_in_b;
    case (func)
      3'd4:    neg_in = (a_neg ^ b_neg) && (reg_in_b != '0);  // x/0 keeps all-ones quotient
      3'd6:    neg_in = a_neg;
      3'd5,
      3'd7:    neg_in = 1'b0;
      default: neg_in = a_neg ^ b_neg;
    endcase
  end

  // one iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH+1:0]   diff;

  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    rsh  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff = {1'b0, rsh} - {2'b00, b_mag};
  end

  // sign-corrected result selection
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd, res;

  always_comb begin
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd  = neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    case (op)
      3'd0:          res = prod[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:          res = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:    res = quo;
      default:       res = rmd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIN;
      FIN:     if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op    <= '0;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      rem   <= '0;
      done  <= 1'b0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op    <= func;
          a_mag <= a_mag_in;
          b_mag <= b_mag_in;
          neg   <= neg_in;
          cnt   <= '0;
          acc   <= {{WIDTH{1'b0}}, (func[2] ? a_mag_in : b_mag_in)};
          rem   <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            rem                 <= diff[WIDTH+1] ? rsh : diff[WIDTH:0];
            acc[WIDTH-1:0]      <= {acc[WIDTH-2:0], ~diff[WIDTH+1]};
          end else begin
            acc <= {msum, acc[WIDTH-1:1]};
          end
        end
        FIN: begin
          // two FIN cycles: register result, then drop done and return to idle
          if (!done) begin
            out  <= res;
            done <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_module_muldiv.sv
// Scoreboard bench for module_muldiv: expected results queued at accept,
// popped and compared on done, with latency and handshake checks.
module tb_module_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func = '0;
  logic [31:0] reg_in_a = '0, reg_in_b = '0;
  logic        busy, done;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  module_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .reg_in_a(reg_in_a), .reg_in_b(reg_in_b),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge right after the accept edge; waits for done and checks it.
  task automatic wait_done(input string name);
    int n = 0;
    logic [31:0] e;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != 33) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (done=%b), want 33", name, n, done);
    end
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard: done with empty queue", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
        failures++;
        $display("FAIL %s result: got %h want %h", name, out, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: done=%b busy=%b after done cycle, want 0 0", name, done, busy);
    end
  endtask

  // Called at a negedge with the unit idle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string name);
    func = f; reg_in_a = a; reg_in_b = b; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; reg_in_a = $urandom; reg_in_b = $urandom; func = 3'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: busy=%b want 1", name, busy);
    end
    wait_done(name);
  endtask

  task automatic test_reset;
    int seen = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b out=%h want 0 0 0", busy, done, out);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_op(3'd0, 32'd7, 32'd3, 32'd21, "mul_7x3");
    func = 3'd0; reg_in_a = 32'd3; reg_in_b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_calc: busy=%b done=%b out=%h want 0 0 0", busy, done, out);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done cycles want 0", seen);
    end
  endtask

  task automatic test_mul;
    run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run_op(3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, "mulh");
    run_op(3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, "mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ff");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_minmin");
  endtask

  task automatic test_div;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu");
    run_op(3'd7, 32'hFFFFFFF9, 32'd2, 32'h00000001, "remu");
  endtask

  task automatic test_div_corner;
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
    run_op(3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div_neg_by0");
    run_op(3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem_neg_by0");
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(f, a, b, model(f, a, b), "random");
    end
  endtask

  task automatic test_ignore_start;
    int seen = 0;
    func = 3'd0; reg_in_a = 32'd9; reg_in_b = 32'd11; start = 1'b1;
    exp_q.push_back(32'd99);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    func = 3'd5; reg_in_a = 32'd100; reg_in_b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done_from(6, "ignore_start");
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++;
    if (seen != 0 || out !== 32'd99) begin
      failures++;
      $display("FAIL ignore_start_after: active=%0d out=%h want 0 %h", seen, out, 32'd99);
    end
  endtask

  // Like wait_done but entered k edges after accept.
  task automatic wait_done_from(input int k, input string name);
    int n = k;
    logic [31:0] e;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != 33) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (done=%b), want 33", name, n, done);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (out !== e) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, out, e);
    end
  endtask

  task automatic test_back_to_back;
    int acc_at[$];
    logic prev_busy;
    logic [31:0] e;
    func = 3'd4; reg_in_a = 32'd1000; reg_in_b = 32'd7; start = 1'b1;
    prev_busy = busy;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        acc_at.push_back(i);
        exp_q.push_back(32'd142);
      end
      if (done === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        checks++;
        if (out !== e) begin
          failures++;
          $display("FAIL b2b result: got %h want %h", out, e);
        end
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checks++;
    if (acc_at.size() != 4) begin
      failures++;
      $display("FAIL b2b accepts: got %0d want 4", acc_at.size());
    end
    for (int i = 1; i < acc_at.size(); i++) begin
      checks++;
      if (acc_at[i] - acc_at[i-1] != 35) begin
        failures++;
        $display("FAIL b2b gap: got %0d want 35", acc_at[i] - acc_at[i-1]);
      end
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
          failures++;
          $display("FAIL b2b drain: got %h want %h", out, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b pending: got %0d outstanding want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_mul;
    test_div;
    test_div_corner;
    test_random;
    test_ignore_start;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
